// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs symbolic LEGv8 instructions into 32-bit words and writes them to consecutive imem addresses
//   CLK/resetl: clock, async active-low reset; start/base_addr: open a session at base_addr
//   in_valid/in_ready/in_last + op_sel/rd/rn/rm/imm/hw: instruction handshake and fields
//   imem_we/imem_addr/imem_wdata: one-cycle write port; busy/done/full/err/word_count: session status
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [25:0]       imm,
  input  logic [1:0]        hw,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  state_t state_q, state_d;
  logic [ADDR_W:0] word_count_q, word_count_d, wc_inc;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d, waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d, enc;
  logic we_q, we_d, err_q, err_d, full_q, full_d, legal, accept;
  always_comb begin
    enc = 32'd0;
    legal = 1'b1;
    case (op_sel)
      4'd0: enc = {11'b10001010000, rm, 6'd0, rn, rd};
      4'd1: enc = {11'b10101010000, rm, 6'd0, rn, rd};
      4'd2: enc = {11'b10001011000, rm, 6'd0, rn, rd};
      4'd3: enc = {11'b11001011000, rm, 6'd0, rn, rd};
      4'd4: begin enc = {10'b1001000100, imm[11:0], rn, rd}; legal = imm[25:12] == 14'd0; end
      4'd5: begin enc = {10'b1101000100, imm[11:0], rn, rd}; legal = imm[25:12] == 14'd0; end
      4'd6: begin enc = {9'b110100101, hw, imm[15:0], rd}; legal = imm[25:16] == 10'd0; end
      4'd7: enc = {6'b000101, imm};
      4'd8: begin enc = {8'b10110100, imm[18:0], rd}; legal = imm[25:18] == {8{imm[18]}}; end
      4'd9: begin enc = {11'b11111000010, imm[8:0], 2'b00, rn, rd}; legal = imm[25:9] == {17{imm[8]}}; end
      4'd10: begin enc = {11'b11111000000, imm[8:0], 2'b00, rn, rd}; legal = imm[25:9] == {17{imm[8]}}; end
      default: legal = 1'b0;
    endcase
  end
  assign in_ready = (state_q == LOAD) && (word_count_q < DEPTH_C);
  assign accept = in_valid && in_ready;
  assign wc_inc = word_count_q + 1'b1;
  always_comb begin
    state_d = state_q;
    word_count_d = word_count_q;
    next_addr_d = next_addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    full_d = full_q;
    we_d = 1'b0;
    err_d = 1'b0;
    if (start && (state_q == IDLE || state_q == DONE)) begin
      state_d = LOAD;
      word_count_d = '0;
      full_d = 1'b0;
      next_addr_d = base_addr;
    end
    if (accept) begin
      we_d = legal;
      err_d = !legal;
      if (legal) begin
        waddr_d = next_addr_q;
        wdata_d = enc;
        next_addr_d = next_addr_q + 1'b1;
        word_count_d = wc_inc;
        full_d = wc_inc == DEPTH_C;
      end
      if (in_last || (legal && wc_inc == DEPTH_C)) state_d = DRAIN;
    end
    if (state_q == DRAIN) state_d = DONE;
  end
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= IDLE;
      word_count_q <= '0;
      next_addr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      full_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_count_q <= word_count_d;
      next_addr_q <= next_addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      full_q <= full_d;
      we_q <= we_d;
      err_q <= err_d;
    end
  end
  assign imem_we = we_q;
  assign imem_addr = waddr_q;
  assign imem_wdata = wdata_q;
  assign busy = (state_q == LOAD) || (state_q == DRAIN);
  assign done = state_q == DONE;
  assign full = full_q;
  assign err = err_q;
  assign word_count = word_count_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: random and directed stimulus checked each cycle against a behavioural model
module tb_instr_encoder_loader;
  localparam int DP = 4;
  logic CLK = 0, resetl = 0, start = 0, in_valid = 0, in_last = 0;
  logic [7:0] base_addr = 0;
  logic [3:0] op_sel = 0;
  logic [4:0] rd = 0, rn = 0, rm = 0;
  logic [25:0] imm = 0;
  logic [1:0] hw = 0;
  logic in_ready, imem_we, busy, done, full, err;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0] word_count;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mem [256];
  int wr_cnt = 0, err_cnt = 0;

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(DP)) dut (
    .CLK(CLK), .resetl(resetl), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .op_sel(op_sel), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .hw(hw),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .full(full), .err(err), .word_count(word_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: fields placed by shift/OR, ranges checked as numeric intervals
  function automatic logic [32:0] ref_enc(input logic [3:0] op, input logic [4:0] d, n, m,
                                          input logic [25:0] im, input logic [1:0] h);
    int s;
    logic [31:0] u, w, rr, rnd;
    logic ok;
    s = int'($signed(im));
    u = {6'd0, im};
    rnd = (32'(n) << 5) | 32'(d);
    rr = (32'(m) << 16) | rnd;
    w = 0;
    ok = 1;
    case (op)
      4'd0: w = (32'h450 << 21) | rr;
      4'd1: w = (32'h550 << 21) | rr;
      4'd2: w = (32'h458 << 21) | rr;
      4'd3: w = (32'h658 << 21) | rr;
      4'd4: begin w = (32'h244 << 22) | ((u & 32'hFFF) << 10) | rnd; ok = u < 4096; end
      4'd5: begin w = (32'h344 << 22) | ((u & 32'hFFF) << 10) | rnd; ok = u < 4096; end
      4'd6: begin w = (32'h1A5 << 23) | (32'(h) << 21) | ((u & 32'hFFFF) << 5) | 32'(d); ok = u < 65536; end
      4'd7: w = (32'h5 << 26) | u;
      4'd8: begin w = (32'hB4 << 24) | ((u & 32'h7FFFF) << 5) | 32'(d); ok = s >= -262144 && s < 262144; end
      4'd9: begin w = (32'h7C2 << 21) | ((u & 32'h1FF) << 12) | rnd; ok = s >= -256 && s < 256; end
      4'd10: begin w = (32'h7C0 << 21) | ((u & 32'h1FF) << 12) | rnd; ok = s >= -256 && s < 256; end
      default: ok = 0;
    endcase
    return {ok, w};
  endfunction

  // Behavioural model: phase 0 idle, 1 loading, 2 draining, 3 done
  int m_st;
  logic [8:0] m_cnt;
  logic [7:0] m_next, e_addr;
  logic [31:0] e_data;
  logic e_we, e_err, e_full;
  logic [32:0] m_r;
  logic m_rdy, m_acc;
  assign m_r = ref_enc(op_sel, rd, rn, rm, imm, hw);
  assign m_rdy = (m_st == 1) && (m_cnt < DP);
  assign m_acc = in_valid && m_rdy;

  always @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      m_st <= 0; m_cnt <= 0; m_next <= 0; e_addr <= 0; e_data <= 0;
      e_we <= 0; e_err <= 0; e_full <= 0;
    end else begin
      e_we <= 0;
      e_err <= 0;
      if ((m_st == 0 || m_st == 3) && start) begin
        m_st <= 1; m_cnt <= 0; e_full <= 0; m_next <= base_addr;
      end else if (m_st == 2) m_st <= 3;
      else if (m_acc) begin
        if (m_r[32]) begin
          e_we <= 1; e_addr <= m_next; e_data <= m_r[31:0];
          m_next <= m_next + 1; m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == DP) e_full <= 1;
        end else e_err <= 1;
        if (in_last || (m_r[32] && m_cnt + 1 == DP)) m_st <= 2;
      end
    end
  end

  always @(negedge CLK) begin
    if (resetl) begin
      chk("in_ready", in_ready, m_rdy);
      chk("imem_we", imem_we, e_we);
      chk("imem_addr", imem_addr, e_addr);
      chk("imem_wdata", imem_wdata, e_data);
      chk("busy", busy, m_st == 1 || m_st == 2);
      chk("done", done, m_st == 3);
      chk("full", full, e_full);
      chk("err", err, e_err);
      chk("word_count", word_count, m_cnt);
      if (imem_we) begin
        mem[imem_addr] <= imem_wdata;
        wr_cnt <= wr_cnt + 1;
      end
      if (err) err_cnt <= err_cnt + 1;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_imem_wdata"}, imem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_word_count"}, word_count, 0);
  endtask

  task automatic do_start(input logic [7:0] b);
    start = 1; base_addr = b;
    @(negedge CLK);
    start = 0;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] d, n, m, input logic [25:0] im,
                      input logic [1:0] h, input bit last, input int bound, output bit acc);
    op_sel = op; rd = d; rn = n; rm = m; imm = im; hw = h; in_last = last; in_valid = 1;
    acc = 0;
    for (int k = 0; k < bound && !acc; k++) begin
      if (in_ready) acc = 1;
      @(negedge CLK);
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic must_send(input logic [3:0] op, input logic [4:0] d, n, m, input logic [25:0] im,
                           input logic [1:0] h, input bit last);
    bit a;
    send(op, d, n, m, im, h, last, 20, a);
    chk("accept_timeout", a, 1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 30 && !done; k++) @(negedge CLK);
    chk("done_timeout", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, e0;
    bit a;
    chk("ref_add", ref_enc(2, 3, 1, 2, 0, 0), {1'b1, 32'h8B020023});
    chk("ref_ldur", ref_enc(9, 5, 4, 0, 26'h3FFFFF8, 0), {1'b1, 32'hF85F8085});
    chk("ref_stur", ref_enc(10, 5, 4, 0, 26'h3FFFFF8, 0), {1'b1, 32'hF81F8085});
    chk("ref_b", ref_enc(7, 0, 0, 0, 26'h3FFFFFF, 0), {1'b1, 32'h17FFFFFF});
    chk("ref_movz", ref_enc(6, 9, 0, 0, 26'hBEEF, 1), {1'b1, 32'hD2B7DDE9});
    chk("ref_cbz_range", ref_enc(8, 0, 0, 0, 26'h40000, 0) >> 32, 0);
    repeat (2) @(negedge CLK);
    chk_reset_vals("reset");
    resetl = 1;
    @(negedge CLK);
    // single ADD
    do_start(8'h10);
    must_send(2, 3, 1, 2, 0, 0, 1);
    chk("add_we", imem_we, 1);
    wait_done();
    chk("add_mem", mem[8'h10], 32'h8B020023);
    chk("add_count", word_count, 1);
    // LDUR/STUR back to back
    do_start(8'h20);
    w0 = wr_cnt;
    must_send(9, 5, 4, 0, 26'h3FFFFF8, 0, 0);
    must_send(10, 5, 4, 0, 26'h3FFFFF8, 0, 1);
    wait_done();
    chk("ldur_mem", mem[8'h20], 32'hF85F8085);
    chk("stur_mem", mem[8'h21], 32'hF81F8085);
    chk("ld_st_writes", wr_cnt - w0, 2);
    // B and MOVZ
    do_start(8'h30);
    must_send(7, 0, 0, 0, 26'h3FFFFFF, 0, 0);
    must_send(6, 9, 0, 0, 26'hBEEF, 1, 1);
    wait_done();
    chk("b_mem", mem[8'h30], 32'h17FFFFFF);
    chk("movz_mem", mem[8'h31], 32'hD2B7DDE9);
    // rejected instructions
    do_start(8'h40);
    w0 = wr_cnt; e0 = err_cnt;
    must_send(8, 1, 0, 0, 26'h40000, 0, 0);
    must_send(12, 1, 2, 3, 0, 0, 1);
    wait_done();
    chk("rej_errs", err_cnt - e0, 2);
    chk("rej_writes", wr_cnt - w0, 0);
    chk("rej_count", word_count, 0);
    // depth limit with address wrap
    do_start(8'hFE);
    for (int i = 0; i < 4; i++) must_send(0, 5'(i), 5'(i + 1), 5'(i + 2), 0, 0, 0);
    chk("full_ready_low", in_ready, 0);
    send(1, 7, 7, 7, 0, 0, 0, 3, a);
    chk("fifth_not_accepted", a, 0);
    wait_done();
    chk("full_flag", full, 1);
    chk("full_count", word_count, DP);
    for (int i = 0; i < 4; i++) chk("wrap_mem", mem[8'(8'hFE + i)], ref_enc(0, 5'(i), 5'(i + 1), 5'(i + 2), 0, 0) & 33'hFFFFFFFF);
    // async reset during a write
    do_start(8'h50);
    must_send(2, 1, 1, 1, 0, 0, 0);
    must_send(3, 2, 2, 2, 0, 0, 0);
    chk("pre_reset_we", imem_we, 1);
    #2 resetl = 0;
    #1 chk_reset_vals("midreset");
    @(negedge CLK);
    resetl = 1;
    @(negedge CLK);
    do_start(8'h60);
    must_send(4, 1, 2, 0, 26'h123, 0, 0);
    must_send(5, 3, 4, 0, 26'hFFF, 0, 0);
    must_send(1, 5, 6, 7, 0, 0, 1);
    wait_done();
    chk("reload_addi", mem[8'h60], ref_enc(4, 1, 2, 0, 26'h123, 0) & 33'hFFFFFFFF);
    chk("reload_orr", mem[8'h62], ref_enc(1, 5, 6, 7, 0, 0) & 33'hFFFFFFFF);
    // random sessions
    for (int s = 0; s < 40; s++) begin
      int n;
      do_start(8'($urandom));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        logic [25:0] im;
        int mode;
        if (!in_ready) break;
        mode = $urandom_range(0, 2);
        im = mode == 0 ? 26'($urandom) : mode == 1 ? 26'($urandom_range(0, 1023) - 512) : 26'($urandom_range(0, 70000));
        if ($urandom_range(0, 3) == 0) begin start = 1; base_addr = 8'($urandom); end
        send(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom), im,
             2'($urandom), i == n - 1, 20, a);
        start = 0;
        chk("rand_accept", a, 1);
        repeat ($urandom_range(0, 1)) @(negedge CLK);
      end
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
